// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: op-size encodings,
// FSM states, access lengths and small decode helpers.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // lsu_ctr encodings
  localparam logic [2:0] CTR_LB  = 3'b000;
  localparam logic [2:0] CTR_LH  = 3'b001;
  localparam logic [2:0] CTR_LW  = 3'b010;
  localparam logic [2:0] CTR_LBU = 3'b100;
  localparam logic [2:0] CTR_LHU = 3'b101;

  // mem_len values (bytes)
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // requester identity, also used for the round-robin flag
  localparam logic SRC_IFU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  function automatic logic ctr_legal(input logic [2:0] c);
    case (c)
      CTR_LB, CTR_LH, CTR_LW, CTR_LBU, CTR_LHU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ctr_len(input logic [2:0] c);
    case (c)
      CTR_LB, CTR_LBU: return LEN_B;
      CTR_LH, CTR_LHU: return LEN_H;
      default:         return LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_load_ext.sv
// Load data extension: sign/zero-extends the addressed byte or halfword
// (already aligned to bit 0 by memory) according to the op size.
module load_ext
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  ctr,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  // pick extension from op size; words and anything else pass through
  always_comb begin
    ext = data;
    case (ctr)
      CTR_LB:  ext = {{24{data[7]}},  data[7:0]};
      CTR_LH:  ext = {{16{data[15]}}, data[15:0]};
      CTR_LBU: ext = {24'd0, data[7:0]};
      CTR_LHU: ext = {16'd0, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store units onto a
// single memory port. One transaction in flight: IDLE -> BUSY -> RESP.
// Illegal op sizes skip memory; stalled accesses abort after TIMEOUT cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_ctr,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_len,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic        bus_err
);

  state_t      state;
  logic        last_gnt;
  logic        src_q;
  logic [2:0]  ctr_q;
  logic [7:0]  cnt;
  logic [31:0] ext_data;
  logic        gnt_ifu, gnt_lsu;

  // grant: lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (state == ST_IDLE && !rst) begin
      gnt_ifu = ifu_valid && (!lsu_valid || last_gnt == SRC_LSU);
      gnt_lsu = lsu_valid && !gnt_ifu;
    end
  end

  assign ifu_ready = gnt_ifu;
  assign lsu_ready = gnt_lsu;

  // extension works on the incoming word so the response registers in the
  // same edge that mem_done is seen
  load_ext u_load_ext (
    .ctr  (ctr_q),
    .data (mem_rdata),
    .ext  (ext_data)
  );

  // transaction FSM with registered memory-side and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_gnt   <= SRC_LSU;
      src_q      <= SRC_IFU;
      ctr_q      <= 3'd0;
      cnt        <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_len    <= 3'd0;
      ifu_rvalid <= 1'b0;
      ifu_rdata  <= 32'd0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= 32'd0;
      err        <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= 8'd0;
          if (gnt_ifu) begin
            src_q     <= SRC_IFU;
            last_gnt  <= SRC_IFU;
            ctr_q     <= CTR_LW;
            mem_addr  <= ifu_addr;
            mem_we    <= 1'b0;
            mem_wdata <= 32'd0;
            mem_len   <= LEN_W;
            mem_req   <= 1'b1;
            state     <= ST_BUSY;
          end else if (gnt_lsu) begin
            src_q     <= SRC_LSU;
            last_gnt  <= SRC_LSU;
            ctr_q     <= lsu_ctr;
            mem_addr  <= lsu_addr;
            mem_we    <= lsu_we;
            mem_wdata <= lsu_wdata;
            mem_len   <= ctr_len(lsu_ctr);
            if (ctr_legal(lsu_ctr)) begin
              mem_req <= 1'b1;
              state   <= ST_BUSY;
            end else begin
              // bad op size never reaches memory; answer with an error now
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= 32'd0;
              err        <= 1'b1;
              bus_err    <= 1'b1;
              state      <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          if (mem_done) begin
            // completion wins even on the last allowed cycle
            mem_req <= 1'b0;
            state   <= ST_RESP;
            if (src_q == SRC_IFU) begin
              ifu_rvalid <= 1'b1;
              ifu_rdata  <= mem_rdata;
            end else begin
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= mem_we ? 32'd0 : ext_data;
            end
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            bus_err <= 1'b1;
            state   <= ST_RESP;
            if (src_q == SRC_IFU) begin
              ifu_rvalid <= 1'b1;
              ifu_rdata  <= 32'd0;
            end else begin
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= 32'd0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          ifu_rvalid <= 1'b0;
          lsu_rvalid <= 1'b0;
          err        <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter. The reference model tracks
// the round-robin winner, the sticky error and the last response per source,
// and derives expected data from the op-size table with plain arithmetic.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid, ifu_ready, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_valid, lsu_ready, lsu_we, lsu_rvalid;
  logic [2:0]  lsu_ctr;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req, mem_we, mem_done, err, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_len;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_last_lsu;
  bit          m_bus_err;
  logic [31:0] m_ifu_rd, m_lsu_rd;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
    .lsu_ctr(lsu_ctr), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .err(err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [2:0] c);
    return (c == 3'b000 || c == 3'b001 || c == 3'b010 || c == 3'b100 || c == 3'b101);
  endfunction

  function automatic logic [31:0] len_of(input logic [2:0] c);
    if (c == 3'b000 || c == 3'b100) return 32'd1;
    if (c == 3'b001 || c == 3'b101) return 32'd2;
    return 32'd4;
  endfunction

  // signed byte/half: value minus 2^n when the top bit is set
  function automatic logic [31:0] exp_load(input logic [2:0] c, input logic [31:0] d);
    int v;
    case (c)
      3'b000:  v = int'(d[7:0])  - (d[7]  ? 256   : 0);
      3'b001:  v = int'(d[15:0]) - (d[15] ? 65536 : 0);
      3'b100:  v = int'(d[7:0]);
      3'b101:  v = int'(d[15:0]);
      default: v = int'(d);
    endcase
    return 32'(v);
  endfunction

  // Starts and ends on an IDLE cycle, 1 time unit after the edge.
  // d = BUSY cycle on which memory answers (d >= TO means never).
  task automatic run_txn(input bit iv, input bit lv, input logic [31:0] ia,
                         input logic [31:0] la, input bit we, input logic [2:0] c,
                         input logic [31:0] wd, input int d, input logic [31:0] rd,
                         input bit keep);
    bit          win_lsu, ill, to, err_exp;
    logic [31:0] exp_rd;
    chk("idle_ifu_rvalid", {31'd0, ifu_rvalid}, 32'd0);
    chk("idle_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    chk("idle_err",        {31'd0, err},        32'd0);
    chk("idle_mem_req",    {31'd0, mem_req},    32'd0);
    chk("hold_ifu_rdata",  ifu_rdata, m_ifu_rd);
    chk("hold_lsu_rdata",  lsu_rdata, m_lsu_rd);
    ifu_valid = iv; ifu_addr = ia;
    lsu_valid = lv; lsu_addr = la; lsu_we = we; lsu_ctr = c; lsu_wdata = wd;
    mem_done = 1'b0;
    #1;
    win_lsu = lv && (!iv || !m_last_lsu);
    chk("ifu_ready", {31'd0, ifu_ready}, {31'd0, iv && !win_lsu});
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, win_lsu});
    m_last_lsu = win_lsu;
    ill = win_lsu && !legal(c);
    to = 1'b0;
    tick();
    if (!keep) begin ifu_valid = 1'b0; lsu_valid = 1'b0; end
    if (!ill) begin
      to = 1'b1;
      for (int k = 0; k < TO; k++) begin
        chk("busy_mem_req",   {31'd0, mem_req},   32'd1);
        chk("busy_ifu_ready", {31'd0, ifu_ready}, 32'd0);
        chk("busy_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        if (k == 0) begin
          chk("mem_addr", mem_addr, win_lsu ? la : ia);
          chk("mem_we",   {31'd0, mem_we}, {31'd0, win_lsu && we});
          chk("mem_len",  {29'd0, mem_len}, win_lsu ? len_of(c) : 32'd4);
          if (win_lsu && we) chk("mem_wdata", mem_wdata, wd);
        end
        if (k == d) begin mem_done = 1'b1; mem_rdata = rd; end
        else begin mem_done = 1'b0; mem_rdata = $urandom; end
        tick();
        mem_done = 1'b0;
        if (k == d) begin to = 1'b0; break; end
      end
    end
    err_exp = ill || to;
    if (err_exp)           exp_rd = 32'd0;
    else if (!win_lsu)     exp_rd = rd;
    else if (we)           exp_rd = 32'd0;
    else                   exp_rd = exp_load(c, rd);
    if (err_exp) m_bus_err = 1'b1;
    chk("resp_mem_req",    {31'd0, mem_req},    32'd0);
    chk("resp_ifu_rvalid", {31'd0, ifu_rvalid}, {31'd0, !win_lsu});
    chk("resp_lsu_rvalid", {31'd0, lsu_rvalid}, {31'd0, win_lsu});
    chk("resp_err",        {31'd0, err},        {31'd0, err_exp});
    chk("resp_bus_err",    {31'd0, bus_err},    {31'd0, m_bus_err});
    chk("resp_ifu_ready",  {31'd0, ifu_ready},  32'd0);
    chk("resp_lsu_ready",  {31'd0, lsu_ready},  32'd0);
    if (win_lsu) begin chk("resp_lsu_rdata", lsu_rdata, exp_rd); m_lsu_rd = exp_rd; end
    else         begin chk("resp_ifu_rdata", ifu_rdata, exp_rd); m_ifu_rd = exp_rd; end
    // a stray completion outside BUSY must be ignored
    mem_done = 1'b1; mem_rdata = $urandom;
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    logic [2:0] ctr_tab [10];
    ctr_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b000, 3'b011, 3'b110, 3'b111};
    rst = 1'b1;
    ifu_valid = 1'b0; ifu_addr = '0;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_ctr = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_done = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_mem_req",   {31'd0, mem_req},    32'd0);
    chk("rst_rvalids",   {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
    chk("rst_err",       {30'd0, err, bus_err}, 32'd0);
    chk("rst_rdata",     ifu_rdata | lsu_rdata, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_mem_len",   {29'd0, mem_len}, 32'd0);
    m_last_lsu = 1'b1; m_bus_err = 1'b0; m_ifu_rd = '0; m_lsu_rd = '0;

    // single fetch, fastest memory
    run_txn(1, 0, 32'h8000_0000, 32'h0, 0, 3'b010, 32'h0, 0, 32'h0000_0413, 0);
    // tie twice, requests held through the first transaction
    run_txn(1, 1, 32'h8000_0004, 32'h8000_1000, 0, 3'b010, 32'h0, 1, 32'hCAFE_0001, 1);
    run_txn(1, 1, 32'h8000_0004, 32'h8000_1000, 0, 3'b010, 32'h0, 0, 32'hCAFE_0002, 0);
    // load extensions
    run_txn(0, 1, 32'h0, 32'h8000_1001, 0, 3'b000, 32'h0, 0, 32'h0000_00F0, 0);
    run_txn(0, 1, 32'h0, 32'h8000_1001, 0, 3'b100, 32'h0, 2, 32'h0000_00F0, 0);
    run_txn(0, 1, 32'h0, 32'h8000_1002, 0, 3'b001, 32'h0, 0, 32'h0000_8001, 0);
    // halfword store
    run_txn(0, 1, 32'h0, 32'h8000_1002, 1, 3'b001, 32'h0000_1234, 1, 32'hDEAD_BEEF, 0);
    // completion on the last allowed cycle is a success
    run_txn(0, 1, 32'h0, 32'h8000_2000, 0, 3'b101, 32'h0, TO - 1, 32'h0000_F00D, 0);
    // timeout, then an illegal op size
    run_txn(0, 1, 32'h0, 32'h8000_3000, 0, 3'b010, 32'h0, 99, 32'h1111_1111, 0);
    run_txn(0, 1, 32'h0, 32'h8000_3004, 0, 3'b011, 32'h0, 0, 32'h2222_2222, 0);
    run_txn(1, 0, 32'h8000_0010, 32'h0, 0, 3'b010, 32'h0, 99, 32'h3333_3333, 0);

    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_txn(sel[0], sel[1], $urandom, $urandom, 1'($urandom),
              ctr_tab[$urandom_range(0, 9)], $urandom, $urandom_range(0, 5), $urandom, 0);
    end

    // reset in the middle of a load: no response, everything cleared
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_ctr = 3'b010; lsu_addr = 32'h8000_4000;
    #1;
    chk("mid_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    chk("mid_busy_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req",     {31'd0, mem_req}, 32'd0);
    chk("mid_rst_bus_err", {31'd0, bus_err}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      mem_done = 1'b1; mem_rdata = $urandom;
      tick();
      chk("mid_no_rvalid", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
      chk("mid_no_req",    {31'd0, mem_req}, 32'd0);
    end
    mem_done = 1'b0;
    m_last_lsu = 1'b1; m_bus_err = 1'b0; m_ifu_rd = '0; m_lsu_rd = '0;
    run_txn(1, 1, 32'h8000_0020, 32'h8000_5000, 0, 3'b010, 32'h0, 0, 32'h4444_4444, 0);
    run_txn(1, 1, 32'h8000_0020, 32'h8000_5000, 0, 3'b000, 32'h0, 0, 32'h0000_0080, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
